mt9v034_capture: RTL and testbench



---
 rtl/mt9v034_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/mt9v034_capture.sv | 204 ++++++++++++++++++++
 tb/tb_mt9v034_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt9v034_pkg.sv
// Shared types and default constants for the MT9V034 single-frame snapshot engine.
package mt9v034_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    SYNC,
    ARM,
    CAPTURE,
    DONE
  } cap_state_e;

  localparam int unsigned CAM_CLK_HZ      = 24_000_000;
  localparam int unsigned DEF_H_ACTIVE    = 752;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_DATA_W      = 10;
  localparam int unsigned DEF_ADDR_W      = 19;
  // 1 us trigger pulse and 100 ms frame wait at the camera clock rate
  localparam int unsigned DEF_TRIG_CYC    = CAM_CLK_HZ / 1_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = CAM_CLK_HZ / 10;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a 1-bit level once and flags its rising/falling edges against the previous registered value.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/mt9v034_capture.sv
// Snapshot engine: trigger pulse on button edge, then capture the next full frame
// as a linear address/data/enable write stream.
module mt9v034_capture
  import mt9v034_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_db,
  input  logic [DATA_W-1:0] cam_dout,
  input  logic              cam_lv,
  input  logic              cam_fv,
  output logic              cam_trigger,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_size,
  output logic              err_timeout
);

  localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W  = $clog2(V_ACTIVE + 1);
  localparam int unsigned TRIG_W = $clog2(TRIG_CYC + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  logic              trig_rise, trig_q_unused, trig_fall_unused;
  logic              lv, lv_rise, lv_fall;
  logic              fv, fv_rise, fv_fall;
  logic [DATA_W-1:0] dout;

  cap_state_e        state, state_n;
  logic [TRIG_W-1:0] trig_cnt, trig_cnt_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic [COL_W-1:0]  col, col_n, col_eff;
  logic [ROW_W-1:0]  row, row_n, row_eff;
  logic [ADDR_W-1:0] addr, addr_n, addr_eff;
  logic [ADDR_W-1:0] base, base_n;
  logic              wr_en_n, err_size_n, err_timeout_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;

  sync_edge_det u_trig (
    .clk    (clk),
    .reset  (reset),
    .d      (trig_db),
    .q      (trig_q_unused),
    .rise_c (trig_rise),
    .fall_c (trig_fall_unused)
  );

  sync_edge_det u_lv (
    .clk    (clk),
    .reset  (reset),
    .d      (cam_lv),
    .q      (lv),
    .rise_c (lv_rise),
    .fall_c (lv_fall)
  );

  sync_edge_det u_fv (
    .clk    (clk),
    .reset  (reset),
    .d      (cam_fv),
    .q      (fv),
    .rise_c (fv_rise),
    .fall_c (fv_fall)
  );

  // A new line restarts at column 0 and at the line base address in the same cycle
  assign col_eff  = lv_rise ? '0 : col;
  assign addr_eff = lv_rise ? base : addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    trig_cnt_n    = trig_cnt;
    tmo_cnt_n     = tmo_cnt;
    col_n         = col;
    row_n         = row;
    row_eff       = row;
    addr_n        = addr;
    base_n        = base;
    wr_en_n       = 1'b0;
    wr_addr_n     = wr_addr;
    wr_data_n     = wr_data;
    err_size_n    = err_size;
    err_timeout_n = err_timeout;

    case (state)
      IDLE: begin
        if (trig_rise) begin
          state_n       = TRIG;
          trig_cnt_n    = '0;
          tmo_cnt_n     = '0;
          err_size_n    = 1'b0;
          err_timeout_n = 1'b0;
        end
      end

      TRIG: begin
        if (trig_cnt == TRIG_W'(TRIG_CYC - 1)) state_n = SYNC;
        else                                   trig_cnt_n = trig_cnt + TRIG_W'(1);
      end

      SYNC, ARM: begin
        tmo_cnt_n = tmo_cnt + TMO_W'(1);
        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_n       = IDLE;
          err_timeout_n = 1'b1;
        end else if (state == SYNC) begin
          if (!fv) state_n = ARM;
        end else if (fv_rise) begin
          state_n = CAPTURE;
          col_n   = '0;
          row_n   = '0;
          addr_n  = '0;
          base_n  = '0;
        end
      end

      CAPTURE: begin
        if (lv) begin
          col_n = (col_eff == COL_W'(H_ACTIVE)) ? col_eff : col_eff + COL_W'(1);
          if (col_eff < COL_W'(H_ACTIVE) && row < ROW_W'(V_ACTIVE)) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr_eff;
            wr_data_n = dout;
            addr_n    = addr_eff + ADDR_W'(1);
          end else begin
            // Excess pixel or excess line: dropped, frame is mis-sized
            err_size_n = 1'b1;
            addr_n     = addr_eff;
          end
        end
        // Line end is accounted before any frame-end check in the same cycle
        if (lv_fall) begin
          if (col != COL_W'(H_ACTIVE)) err_size_n = 1'b1;
          if (row != ROW_W'(V_ACTIVE)) begin
            row_eff = row + ROW_W'(1);
            base_n  = base + ADDR_W'(H_ACTIVE);
          end
          row_n = row_eff;
        end
        if (fv_fall) begin
          if (row_eff != ROW_W'(V_ACTIVE)) err_size_n = 1'b1;
          state_n = DONE;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_cnt    <= '0;
      tmo_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      addr        <= '0;
      base        <= '0;
      dout        <= '0;
      cam_trigger <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      trig_cnt    <= trig_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      col         <= col_n;
      row         <= row_n;
      addr        <= addr_n;
      base        <= base_n;
      dout        <= cam_dout;
      cam_trigger <= (state_n == TRIG);
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      busy        <= (state_n != IDLE);
      frame_done  <= (state_n == DONE);
      err_size    <= err_size_n;
      err_timeout <= err_timeout_n;
    end
  end

endmodule

// File: tb/tb_mt9v034_capture.sv
// Bench for mt9v034_capture: frame-level reference model of expected writes and flags,
// with a per-cycle monitor checking every write strobe and the trigger pulse width.
module tb_mt9v034_capture;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned DW = 10;
  localparam int unsigned AW = 19;
  localparam int unsigned TC = 5;
  localparam int unsigned TO = 200;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk, reset, trig_db, cam_lv, cam_fv;
  logic [DW-1:0] cam_dout;
  logic          cam_trigger, wr_en, busy, frame_done, err_size, err_timeout;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  wr_t    exp_q[$];
  int     lens[8];
  int     wr_cnt = 0, fd_cnt = 0, trig_pulses = 0, trig_len = 0;
  bit     trig_prev = 0, fd_prev = 0, tmo_prev = 0;
  longint trig_fall_cyc = 0, tmo_rise_cyc = -1;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  mt9v034_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW),
    .TRIG_CYC(TC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .trig_db(trig_db), .cam_dout(cam_dout),
    .cam_lv(cam_lv), .cam_fv(cam_fv), .cam_trigger(cam_trigger),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .err_size(err_size), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expected write stream and pulse rules
  task automatic mon();
    wr_t e;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
      chk("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
    if (cam_trigger === 1'b1) trig_len++;
    else if (trig_prev) begin
      chk("trigger_width", trig_len, TC);
      trig_pulses++;
      trig_fall_cyc = cyc;
      trig_len = 0;
    end
    trig_prev = (cam_trigger === 1'b1);
    if (frame_done === 1'b1) begin
      chk("frame_done_one_cycle", 64'(fd_prev), 0);
      fd_cnt++;
    end
    fd_prev = (frame_done === 1'b1);
    if (err_timeout === 1'b1 && !tmo_prev) tmo_rise_cyc = cyc;
    tmo_prev = (err_timeout === 1'b1);
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_trigger();
    trig_db = 1'b1;
    repeat (3) step();
    trig_db = 1'b0;
    repeat (8 + $urandom_range(0, 4)) step();
    chk("trigger_clears_err_size", err_size, 0);
    chk("trigger_clears_err_timeout", err_timeout, 0);
  endtask

  // Drives one frame from lens[] and, when captured, predicts its writes and size error
  task automatic send_frame(input int nlines, input bit capture, input bit seq_data,
                            input bit same_fall, input bit retrig, output bit exp_err);
    int k;
    logic [DW-1:0] d;
    wr_t e;
    k = 1;
    exp_err = (nlines != int'(V));
    cam_fv = 1'b1;
    cam_lv = 1'b0;
    repeat (1 + $urandom_range(0, 2)) step();
    for (int r = 0; r < nlines; r++) begin
      if (lens[r] != int'(H)) exp_err = 1'b1;
      if (retrig) trig_db = (r == 1);
      for (int c = 0; c < lens[r]; c++) begin
        d = seq_data ? DW'(k) : DW'($urandom_range(0, 1023));
        k++;
        if (capture && r < int'(V) && c < int'(H)) begin
          e.addr = AW'(r * int'(H) + c);
          e.data = d;
          exp_q.push_back(e);
        end
        cam_lv   = 1'b1;
        cam_dout = d;
        step();
      end
      cam_lv   = 1'b0;
      cam_dout = DW'($urandom);
      if (r == nlines - 1 && same_fall) cam_fv = 1'b0;
      repeat (1 + $urandom_range(0, 2)) step();
    end
    cam_fv  = 1'b0;
    trig_db = 1'b0;
    repeat (5) step();
  endtask

  task automatic end_checks(input string tag, input int fd_exp, input int wr_exp, input bit err_exp,
                            input int fd0, input int wr0, input int tp0);
    chk({tag, "_frame_done_count"}, fd_cnt - fd0, fd_exp);
    chk({tag, "_write_count"}, wr_cnt - wr0, wr_exp);
    chk({tag, "_err_size"}, err_size, err_exp);
    chk({tag, "_trigger_pulses"}, trig_pulses - tp0, 1);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic full_lines();
    for (int i = 0; i < 8; i++) lens[i] = int'(H);
  endtask

  initial begin
    bit ee;
    int fd0, wr0, tp0, nl;
    reset = 1'b1; trig_db = 1'b0; cam_lv = 1'b0; cam_fv = 1'b0; cam_dout = '0;
    repeat (3) step();
    chk("rst_cam_trigger", cam_trigger, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_size", err_size, 0);
    chk("rst_err_timeout", err_timeout, 0);
    reset = 1'b0;
    repeat (2) step();

    // Nominal frame, data 1..12
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    full_lines();
    do_trigger();
    chk("nominal_busy_armed", busy, 1);
    send_frame(V, 1, 1, 0, 0, ee);
    end_checks("nominal", 1, 12, ee, fd0, wr0, tp0);
    chk("nominal_last_addr", last_addr, 11);
    chk("nominal_last_data", last_data, 'h00C);
    chk("nominal_err_size_lit", err_size, 0);

    // Trigger while a frame is already in flight: partial frame skipped
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    cam_fv = 1'b1;
    repeat (2) step();
    trig_db = 1'b1;
    repeat (3) step();
    trig_db = 1'b0;
    send_frame(V, 0, 0, 0, 0, ee);
    send_frame(V, 1, 0, 1, 0, ee);
    end_checks("midframe", 1, 12, ee, fd0, wr0, tp0);
    chk("midframe_last_addr", last_addr, 11);

    // Long line 1: six pixels, only four written
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    full_lines();
    lens[1] = 6;
    do_trigger();
    send_frame(V, 1, 1, 0, 0, ee);
    end_checks("longline", 1, 12, ee, fd0, wr0, tp0);
    chk("longline_err_lit", err_size, 1);
    chk("longline_last_data", last_data, 14);

    // Short frame: two lines
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    full_lines();
    do_trigger();
    chk("short_err_cleared", err_size, 0);
    send_frame(2, 1, 1, 0, 0, ee);
    end_checks("short", 1, 8, ee, fd0, wr0, tp0);
    chk("short_err_lit", err_size, 1);
    chk("short_last_addr", last_addr, 7);

    // Timeout: no frame ever arrives
    fd0 = fd_cnt; tp0 = trig_pulses;
    tmo_rise_cyc = -1;
    do_trigger();
    for (int i = 0; i < 400 && err_timeout !== 1'b1; i++) step();
    step();
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_delay", 64'(tmo_rise_cyc - trig_fall_cyc), TO);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_frame_done", fd_cnt - fd0, 0);
    chk("timeout_pulses", trig_pulses - tp0, 1);
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    do_trigger();
    send_frame(V, 1, 0, 0, 0, ee);
    end_checks("after_timeout", 1, 12, ee, fd0, wr0, tp0);

    // Reset in the middle of a capture, right after the fifth pixel
    fd0 = fd_cnt; wr0 = wr_cnt;
    do_trigger();
    cam_fv = 1'b1;
    repeat (2) step();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back('{addr: AW'(c), data: DW'(c + 1)});
      cam_lv = 1'b1; cam_dout = DW'(c + 1);
      step();
    end
    cam_lv = 1'b0;
    step();
    exp_q.push_back('{addr: AW'(4), data: DW'(5)});
    cam_lv = 1'b1; cam_dout = DW'(5);
    step();
    cam_lv = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("reset_wr_en", wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cam_trigger", cam_trigger, 0);
    reset = 1'b0; cam_fv = 1'b0;
    repeat (4) step();
    chk("reset_writes", wr_cnt - wr0, 5);
    chk("reset_drained", exp_q.size(), 0);
    chk("reset_no_frame_done", fd_cnt - fd0, 0);
    chk("reset_err_size", err_size, 0);

    // Trigger edge during capture is ignored
    fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
    full_lines();
    do_trigger();
    send_frame(V, 1, 0, 0, 1, ee);
    end_checks("retrig", 1, 12, ee, fd0, wr0, tp0);

    // Randomized frame shapes
    for (int it = 0; it < 8; it++) begin
      fd0 = fd_cnt; wr0 = wr_cnt; tp0 = trig_pulses;
      for (int i = 0; i < 8; i++)
        lens[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, H + 2)) : int'(H);
      nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, V + 1)) : int'(V);
      do_trigger();
      send_frame(nl, 1, 0, 1'($urandom_range(0, 1)), 0, ee);
      chk("rand_frame_done_count", fd_cnt - fd0, 1);
      chk("rand_err_size", err_size, ee);
      chk("rand_trigger_pulses", trig_pulses - tp0, 1);
      chk("rand_busy_idle", busy, 0);
      chk("rand_writes_drained", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
